// File: rtl/spi_pkg.sv
// Shared SPI link definitions used by both the responder and the master.
package spi_pkg;
    localparam int SPI_RX_W        = 32;
    localparam int SPI_TX_W        = 16;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus a history flop for rise/fall detect.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SPI_SYNC_STAGES-1:0] sync_q;
    logic                       hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SPI_SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SPI_SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SPI_SYNC_STAGES-1];
    assign rise_o = q_o & ~hist_q;
    assign fall_o = ~q_o & hist_q;
endmodule

// File: rtl/spi_s.sv
// SPI mode-0 responder: oversamples the link in clk, assembles MSB-first write words
// and shifts a buffered word out on miso for read frames.
module spi_s
    import spi_pkg::*;
#(
    parameter int RX_W = SPI_RX_W,
    parameter int TX_W = SPI_TX_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sclk,
    input  logic            cs_n,
    input  logic            mosi,
    output logic            miso,
    output logic            miso_oe,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_load,
    output logic            tx_ready,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    output logic            tx_done,
    output logic            frame_err
);
    localparam int CW = $clog2(RX_W + 2);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic [SPI_SYNC_STAGES-1:0] mosi_q;
    logic mosi_sync;

    // cs_n chain resets high so the pad stays disabled while in reset.
    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d_i(sclk),
        .q_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst(rst), .d_i(cs_n),
        .q_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mosi_q <= '0;
        else     mosi_q <= {mosi_q[SPI_SYNC_STAGES-2:0], mosi};
    end
    assign mosi_sync = mosi_q[SPI_SYNC_STAGES-1];

    // A frame may only start after cs_n has been seen high post-reset; live_q marks
    // when the cs_n chain holds real samples rather than its reset value.
    logic [1:0] live_q;
    logic       armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            live_q  <= {live_q[0], 1'b1};
            armed_q <= armed_q | (live_q[1] & cs_sync);
        end
    end

    spi_state_e      state_q, state_d;
    logic [RX_W-1:0] rx_shift_q, rx_shift_d;
    logic [TX_W-1:0] tx_shift_q, tx_shift_d, tx_shift_n;
    logic [TX_W-1:0] txbuf_q, txbuf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RX_W-1:0] rx_data_q, rx_data_d;
    logic            tx_ready_q, tx_ready_d;
    logic            miso_q, miso_d;
    logic            rx_valid_q, rx_valid_d;
    logic            tx_done_q, tx_done_d;
    logic            frame_err_q, frame_err_d;

    assign tx_shift_n = tx_shift_q << 1;

    always_comb begin
        state_d     = state_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        txbuf_d     = txbuf_q;
        cnt_d       = cnt_q;
        rx_data_d   = rx_data_q;
        tx_ready_d  = tx_ready_q;
        miso_d      = 1'b0;
        rx_valid_d  = 1'b0;
        tx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d    = ACTIVE;
                    tx_shift_d = tx_ready_q ? '0 : txbuf_q;
                    miso_d     = tx_ready_q ? 1'b0 : txbuf_q[TX_W-1];
                    tx_ready_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            ACTIVE: begin
                miso_d = miso_q;
                if (cs_rise) begin
                    state_d = DONE;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[RX_W-2:0], mosi_sync};
                    if (cnt_q != CW'(RX_W + 1)) cnt_d = cnt_q + CW'(1);
                end else if (sclk_fall) begin
                    tx_shift_d = tx_shift_n;
                    miso_d     = tx_shift_n[TX_W-1];
                end
            end
            DONE: begin
                state_d = IDLE;
                if (cnt_q == CW'(RX_W)) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                end else if (cnt_q == CW'(TX_W)) begin
                    tx_done_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied after the frame-start consume so a same-cycle load keeps new data pending.
        if (tx_load) begin
            txbuf_d    = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            txbuf_q     <= '0;
            cnt_q       <= '0;
            rx_data_q   <= '0;
            tx_ready_q  <= 1'b1;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            txbuf_q     <= txbuf_d;
            cnt_q       <= cnt_d;
            rx_data_q   <= rx_data_d;
            tx_ready_q  <= tx_ready_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            tx_done_q   <= tx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = ~cs_sync;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_done   = tx_done_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_s.sv
// Directed bench for spi_s: drives mode-0 frames at sclk = clk/8 and checks words and pulses.
module tb_spi_s;
    localparam int RX_W = 32;
    localparam int TX_W = 16;

    logic            clk, rst, sclk, cs_n, mosi, miso, miso_oe;
    logic [TX_W-1:0] tx_data;
    logic            tx_load, tx_ready;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid, tx_done, frame_err;

    spi_s #(.RX_W(RX_W), .TX_W(TX_W)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_done(tx_done), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_rxv, n_txd, n_err;
    logic [63:0] mi;
    logic        rdy_in, oe_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (rx_valid)  n_rxv++;
            if (tx_done)   n_txd++;
            if (frame_err) n_err++;
        end
    endtask

    // One frame: mosi bits MSB-first from mo[nbits-1:0]; miso sampled at each sclk rise.
    task automatic xfer(input int nbits, input logic [63:0] mo,
                        input logic midload, input logic [15:0] midval);
        n_rxv = 0; n_txd = 0; n_err = 0; mi = '0;
        cs_n = 1'b0;
        mosi = mo[nbits-1];
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            mi   = {mi[62:0], miso};
            if (i == 0) begin rdy_in = tx_ready; oe_in = miso_oe; end
            tick(4);
            sclk = 1'b0;
            if (i + 1 < nbits) mosi = mo[nbits-2-i];
            if (midload && i == 5) begin
                tx_data = midval; tx_load = 1'b1;
                tick(1);
                tx_load = 1'b0;
                tick(3);
            end else begin
                tick(4);
            end
        end
        cs_n = 1'b1;
        tick(12);
    endtask

    task automatic load(input logic [15:0] v);
        tx_data = v; tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_load = 1'b0; tx_data = '0;
        n_rxv = 0; n_txd = 0; n_err = 0; mi = '0; rdy_in = 1'b0; oe_in = 1'b0;
        tick(3);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        tick(6);

        // 32-bit write frame
        xfer(32, 64'hA5C3_1E7F, 1'b0, 16'h0);
        chk("wr_rx_valid_cnt", n_rxv, 1);
        chk("wr_rx_data", rx_data, 64'hA5C3_1E7F);
        chk("wr_frame_err", n_err, 0);
        chk("wr_tx_done", n_txd, 0);
        chk("wr_miso_zero", mi[31:0], 0);

        // read frame of a loaded word
        load(16'hBEEF);
        chk("rd_ready_after_load", tx_ready, 0);
        xfer(16, 64'h0, 1'b0, 16'h0);
        chk("rd_miso", mi[15:0], 16'hBEEF);
        chk("rd_tx_done", n_txd, 1);
        chk("rd_ready_in_frame", rdy_in, 1);
        chk("rd_oe_in_frame", oe_in, 1);
        chk("rd_oe_after", miso_oe, 0);
        chk("rd_rx_valid", n_rxv, 0);
        chk("rd_rx_data_kept", rx_data, 64'hA5C3_1E7F);

        // read frame with empty buffer
        xfer(16, 64'hFFFF, 1'b0, 16'h0);
        chk("empty_miso", mi[15:0], 0);
        chk("empty_tx_done", n_txd, 1);
        chk("empty_err", n_err, 0);

        // short frame
        xfer(7, 64'h55, 1'b0, 16'h0);
        chk("short_err", n_err, 1);
        chk("short_rx_valid", n_rxv, 0);
        chk("short_tx_done", n_txd, 0);
        chk("short_rx_data", rx_data, 64'hA5C3_1E7F);

        // overrun frame
        xfer(33, 64'h1_FFFF_FFFF, 1'b0, 16'h0);
        chk("over_err", n_err, 1);
        chk("over_rx_valid", n_rxv, 0);
        chk("over_rx_data", rx_data, 64'hA5C3_1E7F);

        // load during a frame only affects the next one
        load(16'hBEEF);
        xfer(16, 64'h0, 1'b0 | 1'b1, 16'h1234);
        chk("mid_cur_miso", mi[15:0], 16'hBEEF);
        chk("mid_ready_after", tx_ready, 0);
        xfer(16, 64'h0, 1'b0, 16'h0);
        chk("mid_next_miso", mi[15:0], 16'h1234);
        chk("mid_next_ready", tx_ready, 1);

        // reset in the middle of a frame
        cs_n = 1'b0; mosi = 1'b1;
        tick(4);
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1; tick(4);
            sclk = 1'b0; tick(4);
            if (i == 3) load(16'h5555);
        end
        chk("pre_rst_ready", tx_ready, 0);
        rst = 1'b1;
        tick(2);
        chk("mrst_miso", miso, 0);
        chk("mrst_oe", miso_oe, 0);
        chk("mrst_rx_data", rx_data, 0);
        chk("mrst_ready", tx_ready, 1);
        chk("mrst_err", frame_err, 0);
        rst = 1'b0;
        tick(8);
        cs_n = 1'b1;
        n_rxv = 0; n_txd = 0; n_err = 0;
        tick(8);
        chk("mrst_no_pulse", n_rxv + n_txd + n_err, 0);
        xfer(32, 64'h0000_0001, 1'b0, 16'h0);
        chk("post_rst_rx_data", rx_data, 64'h1);
        chk("post_rst_rx_valid", n_rxv, 1);
        chk("post_rst_err", n_err, 0);
        chk("post_rst_miso", mi[31:0], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
